// File: rtl/noc_test_node.sv
// -----------------------------------------------------------------------------
// noc_test_node
//
// Traffic generator / checker endpoint for one local port of a NoC router.
//
// Send side: after reset, emits NUM_PKTS packets of PKT_LEN flits each,
// addressed to (DEST_X_ID, DEST_Y_ID). Packets are separated by GAP idle
// cycles.
//
// Receive side: sinks every inbound flit and counts complete packets whose
// header addresses this node. The count is reported on receive_num and
// saturates at 255.
//
// The two sides are independent and run at the same time.
//
// Ports
//   noc_clk            in   clock, rising edge
//   noc_rst_n          in   synchronous reset, ACTIVE-HIGH despite the name
//   receive_valid      in   inbound flit valid
//   receive_ready      out  inbound flit accepted (1 whenever out of reset)
//   receive_flit       in   inbound flit [DATA_WIDTH]
//   receive_is_header  in   inbound flit is a header
//   receive_is_tail    in   inbound flit is a tail
//   sender_valid       out  outbound flit valid
//   sender_ready       in   network accepts outbound flit
//   sender_flit        out  outbound flit [DATA_WIDTH]
//   sender_is_header   out  outbound flit is a header
//   sender_is_tail     out  outbound flit is a tail
//   receive_num        out  good packets received, saturating at 255
//
// Header flit layout:
//   [DW-1:DW-4]   dest X
//   [DW-5:DW-8]   dest Y
//   [DW-9:DW-12]  src X
//   [DW-13:DW-16] src Y
//   [7:0]         seq
//
// Payload flit k layout:
//   [15:8]        seq
//   [7:0]         k
// -----------------------------------------------------------------------------
module noc_test_node #(
    parameter int X_ID       = 0,
    parameter int Y_ID       = 0,
    parameter int DEST_X_ID  = 1,
    parameter int DEST_Y_ID  = 1,
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 4,
    parameter int NUM_PKTS   = 16,
    parameter int GAP        = 2
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst_n,
    input  logic                  receive_valid,
    output logic                  receive_ready,
    input  logic [DATA_WIDTH-1:0] receive_flit,
    input  logic                  receive_is_header,
    input  logic                  receive_is_tail,
    output logic                  sender_valid,
    input  logic                  sender_ready,
    output logic [DATA_WIDTH-1:0] sender_flit,
    output logic                  sender_is_header,
    output logic                  sender_is_tail,
    output logic [7:0]            receive_num
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD,
        S_BODY,
        S_TAIL,
        S_GAP,
        S_DONE
    } state_t;

    // Flit index k runs 0..PKT_LEN-1.
    localparam int IDX_W = $clog2(PKT_LEN);

    // The gap counter runs 0..GAP-1.
    localparam int GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    // ---------------------------------------------------------------------
    // Sender
    // ---------------------------------------------------------------------
    state_t             r_state;
    state_t             w_next_state;
    logic [7:0]         r_seq;
    logic [IDX_W-1:0]   r_idx;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_idle_done;   // IDLE lasts one full cycle after release

    logic               w_send_hs;
    logic               w_last_pkt;
    logic               w_last_body;
    logic               w_gap_end;

    assign w_send_hs   = sender_valid && sender_ready;
    assign w_last_pkt  = ((9'(r_seq) + 9'd1) == 9'(NUM_PKTS));
    assign w_last_body = (r_idx == IDX_W'(PKT_LEN - 2));
    assign w_gap_end   = (r_gap_cnt == GAP_W'(GAP_LAST));

    // State register
    // NOTE: sequential state is always assigned with <= so that every flop
    // samples pre-edge values; mixing in = here creates ordering races.
    always_ff @(posedge noc_clk) begin
        if (noc_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (r_idle_done) w_next_state = S_HEAD;
            S_HEAD: if (w_send_hs)   w_next_state = (PKT_LEN == 2) ? S_TAIL : S_BODY;
            S_BODY: if (w_send_hs && w_last_body) w_next_state = S_TAIL;
            S_TAIL: begin
                if (w_send_hs) begin
                    if (w_last_pkt)    w_next_state = S_DONE;
                    else if (GAP == 0) w_next_state = S_HEAD;
                    else               w_next_state = S_GAP;
                end
            end
            S_GAP:  if (w_gap_end) w_next_state = S_HEAD;
            S_DONE: w_next_state = S_DONE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Sequence number, flit index and gap counter.
    // Counters only move on a handshake, so the presented flit holds while stalled.
    always_ff @(posedge noc_clk) begin
        if (noc_rst_n) begin
            r_seq       <= '0;
            r_idx       <= '0;
            r_gap_cnt   <= '0;
            r_idle_done <= 1'b0;
        end else begin
            r_idle_done <= 1'b1;
            if (w_send_hs) begin
                if (r_state == S_TAIL) begin
                    r_seq <= r_seq + 8'd1;
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
            if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    // Output logic: flits are a pure function of registered state.
    always_comb begin
        sender_valid     = 1'b0;
        sender_flit      = '0;
        sender_is_header = 1'b0;
        sender_is_tail   = 1'b0;
        case (r_state)
            S_HEAD: begin
                sender_valid                      = 1'b1;
                sender_is_header                  = 1'b1;
                sender_flit[DATA_WIDTH-1  -: 4]   = 4'(DEST_X_ID);
                sender_flit[DATA_WIDTH-5  -: 4]   = 4'(DEST_Y_ID);
                sender_flit[DATA_WIDTH-9  -: 4]   = 4'(X_ID);
                sender_flit[DATA_WIDTH-13 -: 4]   = 4'(Y_ID);
                sender_flit[7:0]                  = r_seq;
            end
            S_BODY, S_TAIL: begin
                sender_valid      = 1'b1;
                sender_is_tail    = (r_state == S_TAIL);
                sender_flit[15:8] = r_seq;
                sender_flit[7:0]  = 8'(r_idx);
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Receiver
    // ---------------------------------------------------------------------
    logic       r_receive_ready;
    logic       r_rx_open;      // a header has been seen and no tail yet
    logic       r_rx_match;     // open packet is addressed to this node
    logic [7:0] r_receive_num;

    logic       w_rx_hs;
    logic       w_hdr_match;
    logic       w_pkt_match;
    logic       w_pkt_open;
    logic       w_unused_flit_bits;

    assign w_rx_hs     = receive_valid && r_receive_ready;
    assign w_hdr_match = (receive_flit[DATA_WIDTH-1 -: 4] == 4'(X_ID)) &&
                         (receive_flit[DATA_WIDTH-5 -: 4] == 4'(Y_ID));

    // A flit that carries both flags is a one-flit packet judged on its own header.
    assign w_pkt_match = receive_is_header ? w_hdr_match : r_rx_match;
    assign w_pkt_open  = receive_is_header || r_rx_open;

    // Only the destination field is examined by the sink.
    assign w_unused_flit_bits = ^receive_flit[DATA_WIDTH-9:0];

    always_ff @(posedge noc_clk) begin
        if (noc_rst_n) begin
            r_receive_ready <= 1'b0;
            r_rx_open       <= 1'b0;
            r_rx_match      <= 1'b0;
            r_receive_num   <= '0;
        end else begin
            r_receive_ready <= 1'b1;
            if (w_rx_hs) begin
                if (receive_is_tail) begin
                    r_rx_open  <= 1'b0;
                    r_rx_match <= 1'b0;
                    if (w_pkt_open && w_pkt_match && (r_receive_num != 8'hFF)) begin
                        r_receive_num <= r_receive_num + 8'd1;
                    end
                end else if (receive_is_header) begin
                    // A fresh header restarts tracking even if a packet is open.
                    r_rx_open  <= 1'b1;
                    r_rx_match <= w_hdr_match;
                end
            end
        end
    end

    assign receive_ready = r_receive_ready;
    assign receive_num   = r_receive_num;

endmodule

// File: tb/tb_noc_test_node.sv
// -----------------------------------------------------------------------------
// tb_noc_test_node
//
// Self-checking bench for noc_test_node.
//
// u_dut is node (0,0) sending to (1,1) with PKT_LEN=4, GAP=2 and NUM_PKTS=3.
// Its send side is checked with sender_ready held high and with random
// stalls. Its receive side is driven directly by the bench.
//
// u_loop is node (2,3) sending to itself with PKT_LEN=2, GAP=0 and
// NUM_PKTS=5. Its sender outputs are wired straight back into its receiver.
//
// Expected flits come from the packet-format rules: flit n of the stream
// belongs to packet n/PKT_LEN at index n%PKT_LEN. The expected receive count
// is a saturating tally of matching packets sent by the bench.
// -----------------------------------------------------------------------------
module tb_noc_test_node;

    localparam int DW        = 32;
    localparam int T_PKT_LEN = 4;
    localparam int T_GAP     = 2;
    localparam int T_NUM     = 3;
    localparam int TOTAL     = T_PKT_LEN * T_NUM;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // u_dut signals
    logic          s_valid, s_ready, s_hdr, s_tail;
    logic [DW-1:0] s_flit;
    logic          r_valid, r_ready, r_hdr, r_tail;
    logic [DW-1:0] r_flit;
    logic [7:0]    r_num;

    // u_loop signals
    logic          l_valid, l_ready, l_hdr, l_tail;
    logic [DW-1:0] l_flit;
    logic [7:0]    l_num;

    int n_vec   = 0;
    int n_err   = 0;
    int exp_num = 0;

    noc_test_node #(
        .X_ID(0), .Y_ID(0), .DEST_X_ID(1), .DEST_Y_ID(1),
        .DATA_WIDTH(DW), .PKT_LEN(T_PKT_LEN), .NUM_PKTS(T_NUM), .GAP(T_GAP)
    ) u_dut (
        .noc_clk           (clk),
        .noc_rst_n         (rst),
        .receive_valid     (r_valid),
        .receive_ready     (r_ready),
        .receive_flit      (r_flit),
        .receive_is_header (r_hdr),
        .receive_is_tail   (r_tail),
        .sender_valid      (s_valid),
        .sender_ready      (s_ready),
        .sender_flit       (s_flit),
        .sender_is_header  (s_hdr),
        .sender_is_tail    (s_tail),
        .receive_num       (r_num)
    );

    noc_test_node #(
        .X_ID(2), .Y_ID(3), .DEST_X_ID(2), .DEST_Y_ID(3),
        .DATA_WIDTH(DW), .PKT_LEN(2), .NUM_PKTS(5), .GAP(0)
    ) u_loop (
        .noc_clk           (clk),
        .noc_rst_n         (rst),
        .receive_valid     (l_valid),
        .receive_ready     (l_ready),
        .receive_flit      (l_flit),
        .receive_is_header (l_hdr),
        .receive_is_tail   (l_tail),
        .sender_valid      (l_valid),
        .sender_ready      (l_ready),
        .sender_flit       (l_flit),
        .sender_is_header  (l_hdr),
        .sender_is_tail    (l_tail),
        .receive_num       (l_num)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_s_valid"}, 32'(s_valid), 0);
        check({tag, "_s_flit"},  s_flit,       0);
        check({tag, "_s_hdr"},   32'(s_hdr),   0);
        check({tag, "_s_tail"},  32'(s_tail),  0);
        check({tag, "_r_ready"}, 32'(r_ready), 0);
        check({tag, "_r_num"},   32'(r_num),   0);
    endtask

    // Flit n of the no-reset stream from node (0,0) to (1,1).
    function automatic logic [DW-1:0] exp_flit(input int n);
        int p = n / T_PKT_LEN;
        int k = n % T_PKT_LEN;
        if (k == 0) return {4'd1, 4'd1, 4'd0, 4'd0, 8'h00, 8'(p)};
        return {16'h0000, 8'(p), 8'(k)};
    endfunction

    // Header for a packet sent into u_dut's receiver.
    function automatic logic [DW-1:0] rx_hdr(input int dx, input int dy);
        return {4'(dx), 4'(dy), 4'h3, 4'h7, 16'h005A};
    endfunction

    // Observe the sender one cycle at a time until the full stream plus 10
    // idle cycles has been seen, or until abort_at handshakes are committed.
    task automatic run_sender(input bit rnd, input int abort_at, input bit check_start);
        int            n_hs       = 0;
        int            idle_cnt   = -1;
        int            post       = 0;
        int            k          = 0;
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_flit  = '0;
        logic          prev_hdr   = 1'b0;
        logic          prev_tail  = 1'b0;

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            s_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;

            if (c == 0 && check_start) begin
                check("first_hdr_valid", 32'(s_valid), 1);
                check("first_hdr_flit",  s_flit,       32'h1100_0000);
                check("first_hdr_flag",  32'(s_hdr),   1);
            end

            if (n_hs >= TOTAL) begin
                check("done_valid", 32'(s_valid), 0);
                post++;
                if (post == 10) break;
                continue;
            end

            if (prev_stall) begin
                check("stall_valid", 32'(s_valid), 1);
                check("stall_flit",  s_flit,       prev_flit);
                check("stall_hdr",   32'(s_hdr),   32'(prev_hdr));
                check("stall_tail",  32'(s_tail),  32'(prev_tail));
            end

            k = n_hs % T_PKT_LEN;
            if (!rnd && k != 0) check("b2b_valid", 32'(s_valid), 1);

            if (s_valid) begin
                if (idle_cnt >= 0) begin
                    check("gap_len", 32'(idle_cnt), T_GAP);
                    idle_cnt = -1;
                end
                if (s_ready) begin
                    check("flit",      s_flit,      exp_flit(n_hs));
                    check("hdr_flag",  32'(s_hdr),  32'(k == 0));
                    check("tail_flag", 32'(s_tail), 32'(k == T_PKT_LEN - 1));
                    if (k == T_PKT_LEN - 1) idle_cnt = 0;
                    n_hs++;
                    if (n_hs == abort_at) return;
                end
            end else if (idle_cnt >= 0) begin
                idle_cnt++;
            end

            prev_stall = s_valid && !s_ready;
            prev_flit  = s_flit;
            prev_hdr   = s_hdr;
            prev_tail  = s_tail;
        end

        if (abort_at == 0) check("flit_count", 32'(n_hs), TOTAL);
    endtask

    // Present one flit at a negedge; returns at the negedge after its handshake.
    task automatic rx_flit(input logic [DW-1:0] f, input logic h, input logic t);
        r_valid = 1'b1;
        r_flit  = f;
        r_hdr   = h;
        r_tail  = t;
        @(negedge clk);
        r_valid = 1'b0;
        r_flit  = '0;
        r_hdr   = 1'b0;
        r_tail  = 1'b0;
    endtask

    // Payload flits keep their upper bits zero, so they look like (0,0).
    // A sink that wrongly re-reads the destination from them will miscount.
    task automatic rx_packet(input int dx, input int dy, input int len, input bit idle);
        rx_flit(rx_hdr(dx, dy), 1'b1, 1'b0);
        for (int k = 1; k < len; k++) begin
            if (idle) repeat ($urandom_range(0, 2)) @(negedge clk);
            rx_flit({16'h0000, 8'hC3, 8'(k)}, 1'b0, k == len - 1);
        end
        if (dx == 0 && dy == 0 && exp_num < 255) exp_num++;
    endtask

    initial begin
        s_ready = 1'b1;
        r_valid = 1'b0;
        r_flit  = '0;
        r_hdr   = 1'b0;
        r_tail  = 1'b0;
        rst     = 1'b1;

        // Reset held for 10 cycles: every output stays 0.
        repeat (10) begin
            @(negedge clk);
            check_outputs_zero("reset");
        end

        // Release. The first cycle is IDLE; the header follows one cycle later.
        rst = 1'b0;
        @(negedge clk);
        check("idle_valid", 32'(s_valid), 0);
        check("rx_ready",   32'(r_ready), 1);
        run_sender(1'b0, 0, 1'b1);

        // Loopback has finished 5 packets by now.
        check("loop_num",   32'(l_num),   5);
        check("loop_valid", 32'(l_valid), 0);

        // Receiver: a packet for (1,1) is not counted by node (0,0).
        rx_packet(1, 1, 4, 1'b0);
        check("rx_other_dest", 32'(r_num), 0);

        // Flits with no prior header do not count.
        rx_flit({16'h0, 8'h00, 8'h01}, 1'b0, 1'b0);
        rx_flit({16'h0, 8'h00, 8'h02}, 1'b0, 1'b1);
        check("rx_no_header", 32'(r_num), 0);

        rx_packet(0, 0, 2, 1'b0);
        check("rx_match_min_len", 32'(r_num), 32'(exp_num));

        // A second header restarts tracking.
        rx_flit(rx_hdr(0, 0), 1'b1, 1'b0);
        rx_flit(rx_hdr(1, 1), 1'b1, 1'b0);
        rx_flit({16'h0, 8'h00, 8'h01}, 1'b0, 1'b1);
        check("rx_restart_miss", 32'(r_num), 32'(exp_num));

        rx_flit(rx_hdr(1, 1), 1'b1, 1'b0);
        rx_packet(0, 0, 3, 1'b0);
        check("rx_restart_hit", 32'(r_num), 32'(exp_num));

        // A stray tail after a closed packet does not count.
        rx_flit({16'h0, 8'h00, 8'h05}, 1'b0, 1'b1);
        check("rx_stray_tail", 32'(r_num), 32'(exp_num));

        // Random packets to a mix of destinations, with idle cycles inside.
        for (int i = 0; i < 20; i++) begin
            rx_packet(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                      int'($urandom_range(2, 5)), 1'b1);
            check("rx_random", 32'(r_num), 32'(exp_num));
        end

        // 300 matching packets drive the count into saturation.
        for (int i = 0; i < 300; i++) rx_packet(0, 0, 2, 1'b0);
        check("rx_saturate", 32'(r_num), 255);
        check("rx_model_sat", 32'(r_num), 32'(exp_num));

        // Reset clears the saturated count and everything else.
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_outputs_zero("reset2");
        rst = 1'b0;
        @(negedge clk);

        // Random stalls, then reset in the middle of packet 1.
        run_sender(1'b1, 6, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_abort", 32'(s_valid), 0);

        // Generation restarts at seq 0 and matches the no-stall stream.
        run_sender(1'b1, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/noc_test_node.md
Name: noc_test_node

Overview:
- Traffic-generator/checker endpoint attached to one local port of a NoC router.
- After reset it injects a fixed number of fixed-length packets addressed to (DEST_X_ID, DEST_Y_ID) through a valid/ready flit interface.
- At the same time it sinks all traffic delivered by the network and counts complete packets addressed to itself on receive_num.
- Used in mesh bring-up benches; one instance per active node.

Parameters:
- X_ID, 0, this node's X coordinate (4 bits used).
- Y_ID, 0, this node's Y coordinate (4 bits used).
- DEST_X_ID, 1, destination X coordinate for generated packets.
- DEST_Y_ID, 1, destination Y coordinate for generated packets.
- DATA_WIDTH, 32, flit width; equals the codebase Noc_Data_Width; minimum 32.
- PKT_LEN, 4, flits per packet including header and tail; minimum 2.
- NUM_PKTS, 16, packets to send after reset; range 1..255.
- GAP, 2, idle cycles between a tail handshake and the next header presentation.

Ports:
- noc_clk  in  1  clock; all logic is on the rising edge.
- noc_rst_n  in  1  reset, synchronous, active-high (1 = reset), despite the _n suffix.
- receive_valid  in  1  network has an inbound flit.
- receive_ready  out  1  node accepts the inbound flit.
- receive_flit  in  DATA_WIDTH  inbound flit.
- receive_is_header  in  1  inbound flit is a header.
- receive_is_tail  in  1  inbound flit is a tail.
- sender_valid  out  1  outbound flit valid.
- sender_ready  in  1  network accepts the outbound flit.
- sender_flit  out  DATA_WIDTH  outbound flit.
- sender_is_header  out  1  outbound flit is a header.
- sender_is_tail  out  1  outbound flit is a tail.
- receive_num  out  8  count of good packets received.

Behaviour:
- Reset, synchronous while noc_rst_n=1: sender_valid=0, sender_flit=0, sender_is_header=0, sender_is_tail=0, receive_ready=0, receive_num=0, packet sequence counter=0, FSM=IDLE. Reset asserted mid-packet aborts everything immediately at the next edge.
- Handshake rule: a flit transfers on a rising edge where valid=1 and ready=1. While sender_valid=1 and sender_ready=0, sender_flit, sender_is_header and sender_is_tail are held stable. Valid never drops before its handshake.
- Header flit format:
  - [DW-1:DW-4] = dest X
  - [DW-5:DW-8] = dest Y
  - [DW-9:DW-12] = src X
  - [DW-13:DW-16] = src Y
  - [7:0] = seq
  - all other bits 0
  - sender_is_header=1, sender_is_tail=0
- Payload flit k (k = 1..PKT_LEN-1): [15:8] = seq, [7:0] = k, all other bits 0. is_tail=1 only for k = PKT_LEN-1.
- Header and tail flags are never both 1, because PKT_LEN is at least 2.
- Sender FSM:
  - IDLE: entered when reset is released; moves to HEAD on the next cycle.
  - HEAD: drive the header with valid=1. On handshake go to BODY, or to TAIL if PKT_LEN=2.
  - BODY: drive payload flits k = 1..PKT_LEN-2, one per handshake; after the last one go to TAIL.
  - TAIL: drive the tail flit. On handshake, seq increments; then go to DONE if seq reaches NUM_PKTS, otherwise to GAP.
  - GAP: valid=0 for exactly GAP cycles, then HEAD. GAP=0 means the next header is presented in the cycle right after the tail handshake.
  - DONE: valid=0 permanently until reset.
- Back-to-back flits: with sender_ready held at 1, one flit transfers per cycle inside a packet.
- Receiver:
  - receive_ready=1 every cycle out of reset; the sink never back-pressures.
  - On an accepted header, latch match = (dest X == X_ID and dest Y == Y_ID).
  - On an accepted tail flit, receive_num increments by 1 if match=1, taking effect the cycle after the handshake. It saturates at 255.
  - Non-tail flits, and flits arriving with no prior header, do not change the count.
  - A header accepted while a packet is still open restarts packet tracking.
- Send and receive paths are fully independent and operate simultaneously.

Test Plan:
- Reset held for 10 cycles, then released: during reset all outputs are 0. First header is presented 2 cycles after release; node (0,0) with dest (1,1) drives flit 0x1100_0000 with is_header=1.
- sender_ready tied to 1, PKT_LEN=4, GAP=2, NUM_PKTS=3: exactly 12 flits transfer. Packet pattern is 4 valid cycles then 2 idle. Tail flits of packets 0, 1 and 2 carry 0x0003, 0x0103 and 0x0203. Valid stays 0 after that.
- sender_ready toggled pseudo-randomly: every flit stays stable while stalled, and the flit sequence is identical to the no-stall run.
- Loopback (sender outputs wired to receive inputs, DEST = own ID, NUM_PKTS=5): receive_num ends at 5.
- Inbound packet whose header has dest (1,1) driven into node (0,0): receive_num stays 0.
- 300 matching packets injected into the receiver: receive_num saturates at 255. Reset asserted mid-packet: all outputs return to 0 and generation restarts at seq 0.
